// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting LSU read/write requests onto memory channels
// and relaying read data and completion back to the requesting LSU.
module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]              mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]              mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);
    localparam int CW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] READ_WAITING   = 3'd1;
    localparam logic [2:0] WRITE_WAITING  = 3'd2;
    localparam logic [2:0] READ_RELAYING  = 3'd3;
    localparam logic [2:0] WRITE_RELAYING = 3'd4;

    logic [2:0]               state     [NUM_CHANNELS];
    logic [CW-1:0]            owner     [NUM_CHANNELS];
    logic [CW-1:0]            grant_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CONSUMERS-1:0] serving, taken;
    logic [CW-1:0]            rr, rr_next;
    int                       idx;

    // Idle channels claim candidates in ascending channel order; each claim is hidden from later channels.
    always_comb begin
        taken   = serving;
        rr_next = rr;
        idx     = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant[c]     = 1'b0;
            grant_idx[c] = '0;
            if (state[c] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = (int'(rr) + k) % NUM_CONSUMERS;
                    if (!grant[c] && (consumer_read_valid[idx] || consumer_write_valid[idx]) && !taken[idx]) begin
                        grant[c]     = 1'b1;
                        grant_idx[c] = CW'(idx);
                        taken[idx]   = 1'b1;
                        rr_next      = CW'((idx + 1) % NUM_CONSUMERS);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                owner[c] <= '0;
            end
            serving              <= '0;
            rr                   <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            rr <= rr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (grant[c]) begin
                        owner[c]              <= grant_idx[c];
                        serving[grant_idx[c]] <= 1'b1;
                        if (consumer_read_valid[grant_idx[c]]) begin
                            mem_read_valid[c]                          <= 1'b1;
                            mem_read_address[c*ADDR_BITS +: ADDR_BITS] <= consumer_read_address[int'(grant_idx[c])*ADDR_BITS +: ADDR_BITS];
                            state[c]                                   <= READ_WAITING;
                        end else begin
                            mem_write_valid[c]                          <= 1'b1;
                            mem_write_address[c*ADDR_BITS +: ADDR_BITS] <= consumer_write_address[int'(grant_idx[c])*ADDR_BITS +: ADDR_BITS];
                            mem_write_data[c*DATA_BITS +: DATA_BITS]    <= consumer_write_data[int'(grant_idx[c])*DATA_BITS +: DATA_BITS];
                            state[c]                                    <= WRITE_WAITING;
                        end
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c]                                           <= 1'b0;
                        consumer_read_data[int'(owner[c])*DATA_BITS +: DATA_BITS]  <= mem_read_data[c*DATA_BITS +: DATA_BITS];
                        consumer_read_ready[owner[c]]                               <= 1'b1;
                        state[c]                                                    <= READ_RELAYING;
                    end
                    WRITE_WAITING: if (mem_write_ready[c]) begin
                        mem_write_valid[c]             <= 1'b0;
                        consumer_write_ready[owner[c]] <= 1'b1;
                        state[c]                       <= WRITE_RELAYING;
                    end
                    READ_RELAYING: if (!consumer_read_valid[owner[c]]) begin
                        consumer_read_ready[owner[c]] <= 1'b0;
                        serving[owner[c]]             <= 1'b0;
                        state[c]                      <= IDLE;
                    end
                    WRITE_RELAYING: if (!consumer_write_valid[owner[c]]) begin
                        consumer_write_ready[owner[c]] <= 1'b0;
                        serving[owner[c]]              <= 1'b0;
                        state[c]                       <= IDLE;
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter with one channel (dut a) and two channels (dut b).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  a_crv = '0, a_crr, a_cwv = '0, a_cwr;
    logic [31:0] a_cra = '0, a_crd, a_cwa = '0, a_cwd = '0;
    logic [0:0]  a_mrv, a_mrr = '0, a_mwv, a_mwr = '0;
    logic [7:0]  a_mra, a_mrd = '0, a_mwa, a_mwd;

    logic [3:0]  b_crv = '0, b_crr, b_cwv = '0, b_cwr;
    logic [31:0] b_cra = '0, b_crd, b_cwa = '0, b_cwd = '0;
    logic [1:0]  b_mrv, b_mrr = '0, b_mwv, b_mwr = '0;
    logic [15:0] b_mra, b_mrd = '0, b_mwa, b_mwd;

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
        .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
        .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        n_cmp++; if ({a_mrv, a_mwv, a_crr, a_cwr, a_crd, a_mra, a_mwa, a_mwd} !== '0) begin n_err++; $display("FAIL reset_a: got %h expected 0", {a_mrv, a_mwv, a_crr, a_cwr, a_crd, a_mra, a_mwa, a_mwd}); end
        n_cmp++; if ({b_mrv, b_mwv, b_crr, b_cwr, b_crd, b_mra, b_mwa, b_mwd} !== '0) begin n_err++; $display("FAIL reset_b: got %h expected 0", {b_mrv, b_mwv, b_crr, b_cwr, b_crd, b_mra, b_mwa, b_mwd}); end
        reset = 1'b0;
        tick;
        n_cmp++; if ({a_mrv, a_mwv, a_crr, a_cwr} !== '0) begin n_err++; $display("FAIL idle_after_reset: got %h expected 0", {a_mrv, a_mwv, a_crr, a_cwr}); end
    endtask

    // All four consumers read at once; grants must come in order start, start+1, ... mod 4.
    task automatic test_round_robin(input int start);
        int who;
        logic [7:0] exp_a, exp_d;
        a_crv = 4'hF;
        a_cra = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int i = 0; i < 4; i++) begin
            who   = (start + i) % 4;
            exp_a = 8'h40 + 8'(who);
            exp_d = 8'h80 + 8'(who) + 8'(start);
            tick;
            n_cmp++; if ({a_mrv, a_mra} !== {1'b1, exp_a}) begin n_err++; $display("FAIL rr_grant start=%0d slot=%0d: got valid=%b addr=%h expected valid=1 addr=%h", start, i, a_mrv, a_mra, exp_a); end
            a_mrd = exp_d;
            a_mrr = 1'b1;
            tick;
            n_cmp++; if ({a_mrv, a_crr, a_crd[who*8 +: 8]} !== {1'b0, 4'(1 << who), exp_d}) begin n_err++; $display("FAIL rr_complete start=%0d slot=%0d: got mrv=%b crr=%b data=%h expected mrv=0 crr=%b data=%h", start, i, a_mrv, a_crr, a_crd[who*8 +: 8], 4'(1 << who), exp_d); end
            a_mrr = 1'b0;
            a_crv[who] = 1'b0;
            tick;
            n_cmp++; if (a_crr !== 4'b0000) begin n_err++; $display("FAIL rr_release start=%0d slot=%0d: got crr=%b expected 0000", start, i, a_crr); end
        end
    endtask

    task automatic test_single_read;
        a_crv[2] = 1'b1;
        a_cra[23:16] = 8'h3A;
        tick;
        n_cmp++; if ({a_mrv, a_mra} !== {1'b1, 8'h3A}) begin n_err++; $display("FAIL read_grant: got valid=%b addr=%h expected valid=1 addr=3a", a_mrv, a_mra); end
        tick;
        tick;
        n_cmp++; if ({a_mrv, a_crr} !== {1'b1, 4'b0000}) begin n_err++; $display("FAIL read_wait: got mrv=%b crr=%b expected mrv=1 crr=0000", a_mrv, a_crr); end
        a_mrd = 8'h5C;
        a_mrr = 1'b1;
        tick;
        n_cmp++; if ({a_mrv, a_crr, a_crd[23:16]} !== {1'b0, 4'b0100, 8'h5C}) begin n_err++; $display("FAIL read_complete: got mrv=%b crr=%b data=%h expected mrv=0 crr=0100 data=5c", a_mrv, a_crr, a_crd[23:16]); end
        a_mrr = 1'b0;
        a_mrd = 8'hFF;
        tick;
        n_cmp++; if ({a_mrv, a_crr, a_crd[23:16]} !== {1'b0, 4'b0100, 8'h5C}) begin n_err++; $display("FAIL read_hold: got mrv=%b crr=%b data=%h expected mrv=0 crr=0100 data=5c", a_mrv, a_crr, a_crd[23:16]); end
        a_crv[2] = 1'b0;
        tick;
        n_cmp++; if ({a_crr, a_crd[23:16]} !== {4'b0000, 8'h5C}) begin n_err++; $display("FAIL read_release: got crr=%b data=%h expected crr=0000 data=5c", a_crr, a_crd[23:16]); end
    endtask

    task automatic test_single_write;
        a_cwv[0] = 1'b1;
        a_cwa[7:0] = 8'h10;
        a_cwd[7:0] = 8'hA7;
        tick;
        n_cmp++; if ({a_mwv, a_mwa, a_mwd, a_mrv} !== {1'b1, 8'h10, 8'hA7, 1'b0}) begin n_err++; $display("FAIL write_grant: got mwv=%b addr=%h data=%h mrv=%b expected 1 10 a7 0", a_mwv, a_mwa, a_mwd, a_mrv); end
        a_mwr = 1'b1;
        tick;
        n_cmp++; if ({a_mwv, a_cwr, a_crr} !== {1'b0, 4'b0001, 4'b0000}) begin n_err++; $display("FAIL write_complete: got mwv=%b cwr=%b crr=%b expected 0 0001 0000", a_mwv, a_cwr, a_crr); end
        a_mwr = 1'b0;
        a_cwv[0] = 1'b0;
        tick;
        n_cmp++; if ({a_cwr, a_crr} !== 8'h00) begin n_err++; $display("FAIL write_release: got cwr=%b crr=%b expected 0000 0000", a_cwr, a_crr); end
    endtask

    task automatic test_rw_conflict;
        a_crv[1] = 1'b1;
        a_cwv[1] = 1'b1;
        a_cra[15:8] = 8'h21;
        a_cwa[15:8] = 8'h22;
        a_cwd[15:8] = 8'h33;
        tick;
        n_cmp++; if ({a_mrv, a_mwv, a_mra} !== {1'b1, 1'b0, 8'h21}) begin n_err++; $display("FAIL conflict_read_first: got mrv=%b mwv=%b addr=%h expected 1 0 21", a_mrv, a_mwv, a_mra); end
        a_mrd = 8'h44;
        a_mrr = 1'b1;
        tick;
        n_cmp++; if ({a_crr, a_cwr, a_crd[15:8]} !== {4'b0010, 4'b0000, 8'h44}) begin n_err++; $display("FAIL conflict_read_done: got crr=%b cwr=%b data=%h expected 0010 0000 44", a_crr, a_cwr, a_crd[15:8]); end
        a_mrr = 1'b0;
        a_crv[1] = 1'b0;
        tick;
        n_cmp++; if ({a_crr, a_mwv} !== {4'b0000, 1'b0}) begin n_err++; $display("FAIL conflict_release: got crr=%b mwv=%b expected 0000 0", a_crr, a_mwv); end
        tick;
        n_cmp++; if ({a_mwv, a_mwa, a_mwd, a_mrv} !== {1'b1, 8'h22, 8'h33, 1'b0}) begin n_err++; $display("FAIL conflict_write_grant: got mwv=%b addr=%h data=%h mrv=%b expected 1 22 33 0", a_mwv, a_mwa, a_mwd, a_mrv); end
        a_mwr = 1'b1;
        tick;
        n_cmp++; if (a_cwr !== 4'b0010) begin n_err++; $display("FAIL conflict_write_done: got cwr=%b expected 0010", a_cwr); end
        a_mwr = 1'b0;
        a_cwv[1] = 1'b0;
        tick;
        n_cmp++; if (a_cwr !== 4'b0000) begin n_err++; $display("FAIL conflict_write_release: got cwr=%b expected 0000", a_cwr); end
    endtask

    task automatic test_multi_channel;
        b_crv = 4'b1010;
        b_cra[15:8] = 8'h11;
        b_cra[31:24] = 8'h33;
        tick;
        n_cmp++; if ({b_mrv, b_mra} !== {2'b11, 8'h33, 8'h11}) begin n_err++; $display("FAIL multi_grant: got mrv=%b addr=%h expected 11 3311", b_mrv, b_mra); end
        b_mrd = {8'hB3, 8'hB1};
        b_mrr = 2'b11;
        tick;
        n_cmp++; if ({b_crr, b_crd[31:24], b_crd[15:8], b_mrv} !== {4'b1010, 8'hB3, 8'hB1, 2'b00}) begin n_err++; $display("FAIL multi_complete: got crr=%b d3=%h d1=%h mrv=%b expected 1010 b3 b1 00", b_crr, b_crd[31:24], b_crd[15:8], b_mrv); end
        b_mrr = 2'b00;
        b_crv = 4'b0000;
        tick;
        n_cmp++; if (b_crr !== 4'b0000) begin n_err++; $display("FAIL multi_release: got crr=%b expected 0000", b_crr); end
        b_crv[2] = 1'b1;
        b_cra[23:16] = 8'h22;
        tick;
        n_cmp++; if ({b_mrv, b_mra[7:0]} !== {2'b01, 8'h22}) begin n_err++; $display("FAIL multi_no_double: got mrv=%b addr0=%h expected 01 22", b_mrv, b_mra[7:0]); end
        b_mrd[7:0] = 8'hC2;
        b_mrr = 2'b01;
        tick;
        n_cmp++; if ({b_crr, b_crd[23:16]} !== {4'b0100, 8'hC2}) begin n_err++; $display("FAIL multi_single_complete: got crr=%b data=%h expected 0100 c2", b_crr, b_crd[23:16]); end
        b_mrr = 2'b00;
        b_crv = 4'b0000;
        tick;
    endtask

    task automatic test_reset_mid_read;
        a_crv[1] = 1'b1;
        a_cra[15:8] = 8'h77;
        tick;
        n_cmp++; if ({a_mrv, a_mra} !== {1'b1, 8'h77}) begin n_err++; $display("FAIL midreset_grant: got valid=%b addr=%h expected 1 77", a_mrv, a_mra); end
        tick;
        reset = 1'b1;
        #1;
        n_cmp++; if ({a_mrv, a_mwv, a_crr, a_cwr, a_crd, a_mra, a_mwa, a_mwd} !== '0) begin n_err++; $display("FAIL midreset_clear: got %h expected 0", {a_mrv, a_mwv, a_crr, a_cwr, a_crd, a_mra, a_mwa, a_mwd}); end
        reset = 1'b0;
        a_crv = 4'b0101;
        a_cra[7:0] = 8'h50;
        a_cra[23:16] = 8'h52;
        tick;
        n_cmp++; if ({a_mrv, a_mra} !== {1'b1, 8'h50}) begin n_err++; $display("FAIL midreset_rr_zero: got valid=%b addr=%h expected 1 50", a_mrv, a_mra); end
        a_crv = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_round_robin(0);
        test_single_read;
        test_single_write;
        test_round_robin(1);
        test_rw_conflict;
        test_multi_channel;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory arbiter between the per-thread load/store units and the external data-memory channels. It collects read and write requests from NUM_CONSUMERS LSUs and grants them round-robin onto NUM_CHANNELS memory channels. It forwards each granted request to memory and returns read data and completion to the originating LSU. It speaks the same valid/ready handshake on both sides, so LSUs attach directly.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 4, number of LSU ports (≥1)
- NUM_CHANNELS, 1, number of memory channels (1..NUM_CONSUMERS)

Ports. Consumer i occupies slice `[i*W +: W]` of each packed bus; channel c does the same.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- consumer_read_valid  in  NUM_CONSUMERS  read request per LSU
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  read address, held while valid
- consumer_read_ready  out  NUM_CONSUMERS  read complete; data valid
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  returned read data
- consumer_write_valid  in  NUM_CONSUMERS  write request per LSU
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write address, held while valid
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data, held while valid
- consumer_write_ready  out  NUM_CONSUMERS  write complete
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read done; data valid same cycle
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  channel write address
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write done

## Operation
- Every output is registered. Reset drives all outputs to 0, all channels to IDLE, the serving mask to 0 and the round-robin pointer to 0.
- Per-channel FSM: IDLE → READ_WAITING or WRITE_WAITING → READ_RELAYING or WRITE_RELAYING → IDLE.
- IDLE grant search:
  - Candidates are consumers with read_valid or write_valid set and serving bit clear.
  - Search starts at pointer `rr` and proceeds upward, modulo NUM_CONSUMERS.
  - Idle channels are filled in ascending channel index within a single cycle. Each grant is excluded from the later channels' search in that same cycle.
  - On grant: set the serving bit. If read_valid is set, take the read and copy the address into mem_read_address/mem_read_valid=1, then go to READ_WAITING. Otherwise copy address and data to the mem_write_* outputs with mem_write_valid=1, then go to WRITE_WAITING. Read wins if both valids are set.
  - After the grant cycle, `rr` = (last consumer granted that cycle + 1) mod NUM_CONSUMERS. If nothing was granted, `rr` is unchanged.
- READ_WAITING: on mem_read_ready, clear mem_read_valid, latch mem_read_data into that consumer's consumer_read_data, set consumer_read_ready=1, and go to READ_RELAYING.
- WRITE_WAITING: on mem_write_ready, clear mem_write_valid, set consumer_write_ready=1, and go to WRITE_RELAYING.
- RELAYING: hold ready high until the consumer's corresponding valid is low. Then clear ready, clear the serving bit, and go to IDLE.
  - consumer_read_data keeps its value until the next read completes on that consumer.
- mem_*_ready is ignored in IDLE and RELAYING states.
- A consumer is served by at most one channel at a time.

## Timing
- Grant latency: a consumer valid sampled at edge N gives mem_*_valid high after edge N if a channel is idle.
- Completion: mem_*_ready sampled at edge K gives mem valid low and consumer ready high (with data) after edge K.
- Release: consumer valid low sampled at edge R gives consumer ready low and channel IDLE after edge R. The channel can grant again at edge R+1.
- Minimum transaction with zero-wait memory is 4 cycles from consumer valid to channel reusable.
- Memory holds ready for ≥1 cycle. Ready held longer than that is harmless.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous). Any in-flight memory access is abandoned, so memory must tolerate valid dropping without ready.
- Consumer valid dropping before ready is illegal; behaviour is undefined and is not checked.

## Test plan
- Single read, 1 channel: consumer 2 reads addr 0x3A; memory returns 0x5C after 2 wait cycles → mem_read_address=0x3A, consumer_read_data[2]=0x5C, ready held until valid drops, then channel IDLE.
- Single write: consumer 0 writes 0xA7 to 0x10 → mem_write_address=0x10, mem_write_data=0xA7, consumer_write_ready[0] pulses on completion, consumer_read_ready is never asserted.
- Round-robin, 1 channel: all 4 consumers read at once, zero-wait memory → grant order 0,1,2,3. A second simultaneous burst is granted starting from consumer `rr`, and no consumer is starved.
- Multi-channel, NUM_CHANNELS=2: consumers 1 and 3 request together → channel 0 serves 1 and channel 1 serves 3 in the same cycle, and no consumer is double-granted.
- Read/write conflict: consumer 1 asserts both valids → read is served first, and the write is served in a later grant.
- Reset mid-read: assert reset while in READ_WAITING → all mem and consumer outputs are 0 immediately. After deassert, a new request is granted normally with `rr`=0.
